// File: rtl/sub_share_arbiter_pkg.sv
// Shared types and helpers for the SUB-instance share arbiter.
// Contents: arbiter state enum, default NREQ/HOLD_MAX, one-hot to index.
package sub_arb_pkg;

    localparam int unsigned NREQ_DEFAULT     = 4;
    localparam int unsigned HOLD_MAX_DEFAULT = 8;
    localparam int unsigned NREQ_MAX         = 8;
    localparam int unsigned IDX_MAX_W        = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    // Index of the highest set bit; callers only pass one-hot or zero vectors.
    function automatic int unsigned onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < NREQ_MAX; i++) begin
            if (oh[IDX_MAX_W'(i)]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sub_share_arbiter_if.sv
// Handshake/data bundle between the requesters and the share arbiter.
// master: requester side (REQ, RELEASE, IN_BUS) plus the shared instance output SUB_OUT.
// slave : arbiter side (GNT, SUB_IN, OUT_BUS, BUSY).
interface sub_share_arbiter_if #(
    parameter int unsigned NREQ = 4
) ();
    logic [NREQ-1:0] REQ;
    logic [NREQ-1:0] RELEASE;
    logic [NREQ-1:0] IN_BUS;
    logic            SUB_OUT;
    logic [NREQ-1:0] GNT;
    logic            SUB_IN;
    logic [NREQ-1:0] OUT_BUS;
    logic            BUSY;

    modport master (
        output REQ, RELEASE, IN_BUS, SUB_OUT,
        input  GNT, SUB_IN, OUT_BUS, BUSY
    );

    modport slave (
        input  REQ, RELEASE, IN_BUS, SUB_OUT,
        output GNT, SUB_IN, OUT_BUS, BUSY
    );
endinterface

// File: rtl/sub_arb_rr_pick.sv
// Combinational rotated-priority pick: the first set request at or after ptr wins.
// Ports: req (request vector), ptr (starting index), win_oh (one-hot winner), valid (any request).
module sub_arb_rr_pick
    import sub_arb_pkg::*;
#(
    parameter  int unsigned NREQ  = NREQ_DEFAULT,
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win_oh,
    output logic             valid
);

    int unsigned idx;

    // Walk NREQ positions starting at ptr, wrapping; the first hit is taken.
    always_comb begin
        win_oh = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!valid && req[IDX_W'(idx)]) begin
                win_oh[IDX_W'(idx)] = 1'b1;
                valid               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sub_share_arbiter.sv
// Round-robin arbiter time-sharing one SUB instance between NREQ requesters.
// Ports: CLK, RST (sync, active-high), bus (slave modport: REQ, RELEASE, IN_BUS,
//        SUB_OUT in; GNT, SUB_IN, OUT_BUS, BUSY out).
// Build option: define SUB_ARB_TIMEOUT_EN to preempt an owner after HOLD_MAX owned
// cycles when another requester is waiting.
module sub_share_arbiter
    import sub_arb_pkg::*;
#(
    parameter int unsigned NREQ     = NREQ_DEFAULT,
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input logic              CLK,
    input logic              RST,
    sub_share_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Parameter range guards.
    if (NREQ < 1 || NREQ > NREQ_MAX) begin : g_bad_nreq
        $error("sub_share_arbiter: NREQ out of range");
    end
    if (HOLD_MAX < 1) begin : g_bad_hold
        $error("sub_share_arbiter: HOLD_MAX must be at least 1");
    end

    arb_state_e       state;
    logic [NREQ-1:0]  gnt_q;
    logic [IDX_W-1:0] ptr;

    logic [NREQ-1:0]  win_oh;
    logic             win_valid;
    logic [IDX_W-1:0] ptr_next;
    logic             own_rel;
    logic             own_req;
    logic             end_own;

    sub_arb_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (bus.REQ),
        .ptr    (ptr),
        .win_oh (win_oh),
        .valid  (win_valid)
    );

    // Pointer moves one past the winner so the new owner is last in line next time.
    assign ptr_next = IDX_W'((onehot_to_idx(NREQ_MAX'(win_oh)) + 1) % NREQ);

    // gnt_q is one-hot in OWNED, so masking picks out the owner's bits only.
    assign own_rel = |(bus.RELEASE & gnt_q);
    assign own_req = |(bus.REQ & gnt_q);

`ifdef SUB_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] hold;
    logic              preempt;

    // Held at zero outside OWNED so it starts from zero on every grant; saturates.
    always_ff @(posedge CLK) begin
        if (RST || state != ST_OWNED) begin
            hold <= '0;
        end else if (hold != HOLD_W'(HOLD_MAX)) begin
            hold <= hold + HOLD_W'(1);
        end
    end

    assign preempt = (hold == HOLD_W'(HOLD_MAX)) && (|(bus.REQ & ~gnt_q));
    assign end_own = own_rel || !own_req || preempt;
`else
    assign end_own = own_rel || !own_req;
`endif

    // Ownership FSM; RELEASE is only looked at in OWNED.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            gnt_q <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_GAP: begin
                    if (win_valid) begin
                        state <= ST_OWNED;
                        gnt_q <= win_oh;
                        ptr   <= ptr_next;
                    end else begin
                        state <= ST_IDLE;
                        gnt_q <= '0;
                    end
                end
                ST_OWNED: begin
                    if (end_own) begin
                        state <= ST_GAP;
                        gnt_q <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.GNT     = gnt_q;
    assign bus.BUSY    = (state == ST_OWNED);
    // gnt_q is zero outside OWNED, which forces SUB_IN and OUT_BUS low there.
    assign bus.SUB_IN  = |(bus.IN_BUS & gnt_q);
    assign bus.OUT_BUS = gnt_q & {NREQ{bus.SUB_OUT}};

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Self-checking bench for sub_share_arbiter: scenario tasks push expected
// GNT/BUSY per cycle into a scoreboard queue and pop/compare after each edge.
module tb_sub_share_arbiter;
    import sub_arb_pkg::*;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned HOLD_MAX = 4;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    sub_share_arbiter_if #(.NREQ(NREQ)) bus ();

    sub_share_arbiter #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        string     tag;
        logic [3:0] gnt;
        logic      busy;
    } exp_t;

    typedef struct {
        string     tag;
        logic [3:0] req;
        logic [3:0] rel;
        logic      rst;
        logic [3:0] eg;
        logic      eb;
    } stim_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic stim_t mk(input string tag, input logic [3:0] req, input logic [3:0] rel,
                                 input logic rst, input logic [3:0] eg, input logic eb);
        stim_t s;
        s.tag = tag; s.req = req; s.rel = rel; s.rst = rst; s.eg = eg; s.eb = eb;
        return s;
    endfunction

    // Apply one cycle of stimulus, record what must appear after the edge, advance.
    task automatic drive(input stim_t s);
        exp_t e;
        bus.REQ     = s.req;
        bus.RELEASE = s.rel;
        RST         = s.rst;
        e.tag = s.tag; e.gnt = s.eg; e.busy = s.eb;
        sbq.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        bus.IN_BUS  = 4'b1111;
        bus.SUB_OUT = 1'b1;
        bus.REQ     = 4'b0000;
        bus.RELEASE = 4'b0000;
        RST         = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (bus.GNT !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.GNT); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
        checks++; if (bus.SUB_IN !== 1'b0) begin errors++; $display("FAIL reset_sub_in: got %b want 0", bus.SUB_IN); end
        checks++; if (bus.OUT_BUS !== 4'b0000) begin errors++; $display("FAIL reset_out_bus: got %b want 0000", bus.OUT_BUS); end
    endtask

    task automatic test_single();
        exp_t e;
        bus.IN_BUS  = 4'b0001;
        bus.SUB_OUT = 1'b1;
        drive(mk("single_grant", 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1));
        e = sbq.pop_front();
        checks++; if (bus.GNT !== e.gnt || bus.BUSY !== e.busy) begin
            errors++; $display("FAIL %s: GNT=%b BUSY=%b want GNT=%b BUSY=%b", e.tag, bus.GNT, bus.BUSY, e.gnt, e.busy);
        end
        checks++; if (bus.SUB_IN !== 1'b1) begin errors++; $display("FAIL single_sub_in: got %b want 1", bus.SUB_IN); end
        checks++; if (bus.OUT_BUS !== 4'b0001) begin errors++; $display("FAIL single_out_bus: got %b want 0001", bus.OUT_BUS); end
        bus.IN_BUS = 4'b1110;
        #1;
        checks++; if (bus.SUB_IN !== 1'b0) begin errors++; $display("FAIL single_sub_in_other: got %b want 0", bus.SUB_IN); end
        bus.SUB_OUT = 1'b0;
        #1;
        checks++; if (bus.OUT_BUS !== 4'b0000) begin errors++; $display("FAIL single_out_bus_low: got %b want 0000", bus.OUT_BUS); end
        bus.IN_BUS  = 4'b1111;
        bus.SUB_OUT = 1'b1;
        drive(mk("single_drop", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0));
        drive(mk("single_idle", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0));
        for (int i = 0; i < 2; i++) begin
            e = sbq.pop_front();
            checks++; if (bus.GNT !== e.gnt || bus.BUSY !== e.busy) begin
                errors++; $display("FAIL %s: GNT=%b BUSY=%b want GNT=%b BUSY=%b", e.tag, bus.GNT, bus.BUSY, e.gnt, e.busy);
            end
        end
    endtask

    task automatic test_round_robin();
        stim_t st[$];
        exp_t  e;
        logic [3:0] own;
        st.push_back(mk("rr_rst", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0));
        st.push_back(mk("rr_rst", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0));
        for (int n = 0; n < 5; n++) begin
            own = 4'b0001 << (n % 4);
            st.push_back(mk("rr_own", 4'b1111, 4'b0000, 1'b0, own, 1'b1));
            st.push_back(mk("rr_own", 4'b1111, 4'b0000, 1'b0, own, 1'b1));
            st.push_back(mk("rr_own", 4'b1111, 4'b0000, 1'b0, own, 1'b1));
            st.push_back(mk("rr_gap", 4'b1111, own,     1'b0, 4'b0000, 1'b0));
        end
        st.push_back(mk("rr_idle", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0));
        foreach (st[i]) begin
            drive(st[i]);
            e = sbq.pop_front();
            checks++;
            if (bus.GNT !== e.gnt || bus.BUSY !== e.busy || bus.SUB_IN !== e.busy || bus.OUT_BUS !== e.gnt) begin
                errors++;
                $display("FAIL %s step %0d: GNT=%b BUSY=%b SUB_IN=%b OUT_BUS=%b want GNT=%b BUSY=%b",
                         e.tag, i, bus.GNT, bus.BUSY, bus.SUB_IN, bus.OUT_BUS, e.gnt, e.busy);
            end
        end
    endtask

    task automatic test_implicit_release();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk("imp_rst", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0));
        st.push_back(mk("imp_rst", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0));
        st.push_back(mk("imp_rel_at_grant", 4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1));
        st.push_back(mk("imp_hold", 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1));
        st.push_back(mk("imp_foreign_rel", 4'b0100, 4'b0001, 1'b0, 4'b0100, 1'b1));
        st.push_back(mk("imp_hold2", 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1));
        st.push_back(mk("imp_req_drop", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0));
        st.push_back(mk("imp_idle", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0));
        foreach (st[i]) begin
            drive(st[i]);
            e = sbq.pop_front();
            checks++;
            if (bus.GNT !== e.gnt || bus.BUSY !== e.busy || bus.SUB_IN !== e.busy || bus.OUT_BUS !== e.gnt) begin
                errors++;
                $display("FAIL %s step %0d: GNT=%b BUSY=%b SUB_IN=%b OUT_BUS=%b want GNT=%b BUSY=%b",
                         e.tag, i, bus.GNT, bus.BUSY, bus.SUB_IN, bus.OUT_BUS, e.gnt, e.busy);
            end
        end
    endtask

    task automatic test_priority();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk("pri_rst", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0));
        st.push_back(mk("pri_rst", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0));
        st.push_back(mk("pri_g0", 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1));
        st.push_back(mk("pri_rel0_new1", 4'b0011, 4'b0001, 1'b0, 4'b0000, 1'b0));
        st.push_back(mk("pri_g1", 4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b1));
        st.push_back(mk("pri_rel1_alone", 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0));
        st.push_back(mk("pri_regain1", 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1));
        st.push_back(mk("pri_rel1_others", 4'b1011, 4'b0010, 1'b0, 4'b0000, 1'b0));
        st.push_back(mk("pri_g3", 4'b1011, 4'b0000, 1'b0, 4'b1000, 1'b1));
        st.push_back(mk("pri_rel3", 4'b1011, 4'b1000, 1'b0, 4'b0000, 1'b0));
        st.push_back(mk("pri_wrap_g0", 4'b1011, 4'b0000, 1'b0, 4'b0001, 1'b1));
        st.push_back(mk("pri_rel0", 4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b0));
        st.push_back(mk("pri_idle", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0));
        foreach (st[i]) begin
            drive(st[i]);
            e = sbq.pop_front();
            checks++;
            if (bus.GNT !== e.gnt || bus.BUSY !== e.busy || bus.SUB_IN !== e.busy || bus.OUT_BUS !== e.gnt) begin
                errors++;
                $display("FAIL %s step %0d: GNT=%b BUSY=%b SUB_IN=%b OUT_BUS=%b want GNT=%b BUSY=%b",
                         e.tag, i, bus.GNT, bus.BUSY, bus.SUB_IN, bus.OUT_BUS, e.gnt, e.busy);
            end
        end
    endtask

    task automatic test_hold();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk("hold_rst", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0));
        st.push_back(mk("hold_rst", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0));
        st.push_back(mk("hold_g0", 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1));
`ifdef SUB_ARB_TIMEOUT_EN
        // Counter reads 0..HOLD_MAX across the owned cycles; preempt when it hits HOLD_MAX.
        for (int i = 0; i < HOLD_MAX; i++) begin
            st.push_back(mk("hold_owned", 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1));
        end
        st.push_back(mk("hold_preempt", 4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b0));
        st.push_back(mk("hold_g1", 4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b1));
        st.push_back(mk("hold_drop", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0));
`else
        for (int i = 0; i < 22; i++) begin
            st.push_back(mk("hold_no_timeout", 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1));
        end
        st.push_back(mk("hold_drop", 4'b0010, 4'b0001, 1'b0, 4'b0000, 1'b0));
        st.push_back(mk("hold_g1", 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1));
        st.push_back(mk("hold_drop1", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0));
`endif
        st.push_back(mk("hold_idle", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0));
        foreach (st[i]) begin
            drive(st[i]);
            e = sbq.pop_front();
            checks++;
            if (bus.GNT !== e.gnt || bus.BUSY !== e.busy || bus.SUB_IN !== e.busy || bus.OUT_BUS !== e.gnt) begin
                errors++;
                $display("FAIL %s step %0d: GNT=%b BUSY=%b SUB_IN=%b OUT_BUS=%b want GNT=%b BUSY=%b",
                         e.tag, i, bus.GNT, bus.BUSY, bus.SUB_IN, bus.OUT_BUS, e.gnt, e.busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk("rm_rst", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0));
        st.push_back(mk("rm_rst", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0));
        st.push_back(mk("rm_g0", 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1));
        st.push_back(mk("rm_hold", 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1));
        st.push_back(mk("rm_reset_owned", 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0));
        st.push_back(mk("rm_ptr_restart", 4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b1));
        st.push_back(mk("rm_rel", 4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b0));
        st.push_back(mk("rm_idle", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0));
        foreach (st[i]) begin
            drive(st[i]);
            e = sbq.pop_front();
            checks++;
            if (bus.GNT !== e.gnt || bus.BUSY !== e.busy || bus.SUB_IN !== e.busy || bus.OUT_BUS !== e.gnt) begin
                errors++;
                $display("FAIL %s step %0d: GNT=%b BUSY=%b SUB_IN=%b OUT_BUS=%b want GNT=%b BUSY=%b",
                         e.tag, i, bus.GNT, bus.BUSY, bus.SUB_IN, bus.OUT_BUS, e.gnt, e.busy);
            end
        end
    endtask

    initial begin
        RST         = 1'b1;
        bus.REQ     = '0;
        bus.RELEASE = '0;
        bus.IN_BUS  = '0;
        bus.SUB_OUT = 1'b0;
        @(posedge CLK);
        #1;
        test_reset();
        test_single();
        bus.IN_BUS  = 4'b1111;
        bus.SUB_OUT = 1'b1;
        test_round_robin();
        test_implicit_release();
        test_priority();
        test_hold();
        test_reset_mid();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
